sad_ram_sequencer: RTL and testbench

- Controller for the row-wide line RAM: one write port with a wr_en/full counter, one read port with registered 1-cycle read latency.
- Per frame: pulses the RAM reset, fills it with ROWS lines from an upstream valid/ready stream, then scans the stored lines as overlapping vertical blocks for the SAD datapath.
- Drives the read address and emits sideband (valid, last, block/row index) aligned with the RAM's registered output.
- Row data goes directly from the RAM to the SAD consumer; this block does not carry it.

---
 rtl/sad_ram_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sad_ram_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sad_ram_sequencer.sv
// sad_ram_sequencer: frame controller for the row-wide line RAM.
// Per frame it clears the RAM, fills it with ROWS lines from an upstream
// valid/ready stream, then replays the lines as overlapping vertical blocks.
// The sideband (valid/last/block/row) lines up with the RAM's registered output.
module sad_ram_sequencer #(
   parameter int ROWS   = 480,
   parameter int ADDR_W = 9,
   parameter int BLK_H  = 8,
   parameter int STRIDE = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ram_rst,
   output logic              ram_wr_en,
   input  logic              ram_full,
   output logic [ADDR_W-1:0] ram_rd_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [ADDR_W-1:0] out_blk,
   output logic [ADDR_W-1:0] out_row
);

   localparam int NUM_BLK = (ROWS - BLK_H) / STRIDE + 1;
   localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLK - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(BLK_H - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(STRIDE);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   typedef enum logic [2:0] {IDLE, CLEAR, FILL, SCAN, DONE} state_t;

   state_t state_reg, state_next;

   // "nxt" is the beat to be issued to the RAM next; "pres" is the beat whose
   // data currently sits on the RAM output.
   logic [ADDR_W-1:0] nxt_blk_reg, nxt_row_reg, nxt_base_reg, nxt_addr_reg;
   logic [ADDR_W-1:0] pres_blk_reg, pres_row_reg, pres_addr_reg;
   logic              out_valid_reg, done_reg;

   logic beat_xfer, beat_stall, pres_final, nxt_final, load_beat;

   assign beat_xfer  = out_valid_reg & out_ready;
   assign beat_stall = out_valid_reg & ~out_ready;
   assign pres_final = (pres_blk_reg == LAST_BLK) && (pres_row_reg == LAST_ROW);
   assign nxt_final  = (nxt_blk_reg == LAST_BLK) && (nxt_row_reg == LAST_ROW);
   // A new beat is fetched when the output slot is empty or being drained,
   // unless the beat being drained is the final one of the frame.
   assign load_beat  = (state_reg == SCAN) &&
                       (~out_valid_reg || (out_ready && !pres_final));

   // A stalled beat re-reads its own address so the RAM output stays put.
   assign ram_rd_addr = beat_stall ? pres_addr_reg : nxt_addr_reg;
   assign out_valid   = out_valid_reg;
   assign out_blk     = pres_blk_reg;
   assign out_row     = pres_row_reg;
   assign out_last    = out_valid_reg && (pres_row_reg == LAST_ROW);
   assign done        = done_reg;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and per-state control outputs.
   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      in_ready   = 1'b0;
      ram_wr_en  = 1'b0;
      ram_rst    = rst;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            busy       = 1'b1;
            ram_rst    = 1'b1;
            state_next = FILL;
         end
         FILL: begin
            busy      = 1'b1;
            in_ready  = ~ram_full;
            ram_wr_en = in_valid & ~ram_full;
            if (ram_full) begin
               state_next = SCAN;
            end
         end
         SCAN: begin
            busy = 1'b1;
            if (beat_xfer && pres_final) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Keep the handshake outputs quiet while reset is being applied.
      if (rst) begin
         busy      = 1'b0;
         in_ready  = 1'b0;
         ram_wr_en = 1'b0;
      end
   end

   // Scan counters, presented-beat sideband and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         nxt_blk_reg   <= '0;
         nxt_row_reg   <= '0;
         nxt_base_reg  <= '0;
         nxt_addr_reg  <= '0;
         pres_blk_reg  <= '0;
         pres_row_reg  <= '0;
         pres_addr_reg <= '0;
         out_valid_reg <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (state_reg == CLEAR) begin
            nxt_blk_reg   <= '0;
            nxt_row_reg   <= '0;
            nxt_base_reg  <= '0;
            nxt_addr_reg  <= '0;
            pres_blk_reg  <= '0;
            pres_row_reg  <= '0;
            pres_addr_reg <= '0;
            out_valid_reg <= 1'b0;
         end else if (load_beat) begin
            pres_blk_reg  <= nxt_blk_reg;
            pres_row_reg  <= nxt_row_reg;
            pres_addr_reg <= nxt_addr_reg;
            out_valid_reg <= 1'b1;
            // The final beat is never advanced past, so the read address
            // rests on the last line once the scan completes.
            if (!nxt_final) begin
               if (nxt_row_reg == LAST_ROW) begin
                  nxt_row_reg  <= '0;
                  nxt_blk_reg  <= nxt_blk_reg + ONE;
                  nxt_base_reg <= nxt_base_reg + STEP;
                  nxt_addr_reg <= nxt_base_reg + STEP;
               end else begin
                  nxt_row_reg  <= nxt_row_reg + ONE;
                  nxt_addr_reg <= nxt_addr_reg + ONE;
               end
            end
         end else if ((state_reg == SCAN) && beat_xfer) begin
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sad_ram_sequencer.sv
// Bench for sad_ram_sequencer with ROWS=16, BLK_H=4, STRIDE=2 (7 blocks x 4 lines).
// A behavioural line RAM (write counter + full flag, registered read) sits
// between the sequencer and a scoreboard monitor that checks every beat.
module tb_sad_ram_sequencer;

   localparam int ROWS = 16;
   localparam int AW   = 9;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, out_ready;
   logic          busy, done, in_ready, ram_rst, ram_wr_en, ram_full;
   logic          out_valid, out_last;
   logic [AW-1:0] ram_rd_addr, out_blk, out_row;

   sad_ram_sequencer #(.ROWS(ROWS), .ADDR_W(AW), .BLK_H(4), .STRIDE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .ram_rst(ram_rst),
      .ram_wr_en(ram_wr_en), .ram_full(ram_full), .ram_rd_addr(ram_rd_addr),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_blk(out_blk), .out_row(out_row)
   );

   always #5 clk = ~clk;

   // Line content: frame id in bits [11:8], line index in [7:0].
   function automatic logic [15:0] line_val(input int f, input int i);
      return 16'h3000 | 16'((f % 16) * 256) | 16'(i % 256);
   endfunction

   int frame_id  = 0;
   int ready_pct = 100;
   int valid_pct = 50;

   // Line RAM model: write pointer/counter cleared by ram_rst, registered read.
   logic [15:0] mem [0:15];
   logic [15:0] data_out;
   logic [15:0] in_data;
   logic [4:0]  wr_cnt = '0;
   assign ram_full = (wr_cnt == 5'd16);
   assign in_data  = line_val(frame_id, int'(wr_cnt));
   always @(posedge clk) begin
      if (ram_rst) begin
         wr_cnt <= '0;
      end else if (ram_wr_en && wr_cnt < 5'd16) begin
         mem[wr_cnt[3:0]] <= in_data;
         wr_cnt <= wr_cnt + 5'd1;
      end
      data_out <= mem[ram_rd_addr[3:0]];
   end

   int checks = 0, failures = 0;
   int cyc = 0, rst_pulses = 0, wr_pulses = 0, beat_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          blk;
      int          row;
      bit          last;
      logic [15:0] data;
      bit          fin;
   } exp_t;
   exp_t q[$];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Upstream source and downstream consumer pacing, driven just after the edge.
   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 99) < valid_pct);
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // Monitor: pops expected beats, checks stall stability and done timing.
   logic          stall_prev = 1'b0, done_exp = 1'b0;
   logic [AW-1:0] s_blk, s_row;
   logic          s_last;
   logic [15:0]   s_data;
   exp_t          e;
   initial forever begin
      @(negedge clk);
      if (ram_rst && !rst) rst_pulses++;
      if (ram_wr_en) wr_pulses++;
      if (rst) begin
         stall_prev = 1'b0;
         done_exp   = 1'b0;
      end else begin
         if (done_exp) begin
            chk("done_pulse", {done, out_valid}, 2'b10);
            done_exp = 1'b0;
         end else if (done !== 1'b0) begin
            chk("spurious_done", done, 0);
         end
         if (stall_prev) begin
            chk("stall_hold", {out_valid, out_blk, out_row, out_last, data_out},
                {1'b1, s_blk, s_row, s_last, s_data});
         end
         if (out_valid && out_ready) begin
            beat_cnt++;
            if (q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               e = q.pop_front();
               $display("beat blk=%0d row=%0d last=%0b data=%h", out_blk, out_row, out_last, data_out);
               chk("beat", {out_blk, out_row, out_last, data_out},
                   {AW'(e.blk), AW'(e.row), e.last, e.data});
               if (e.fin) done_exp = 1'b1;
            end
         end
         stall_prev = out_valid && !out_ready;
         s_blk  = out_blk;
         s_row  = out_row;
         s_last = out_last;
         s_data = data_out;
      end
   end

   int blk_start [7] = '{0, 2, 4, 6, 8, 10, 12};

   task automatic run_frame(input int fid, input int rpct, input bit poke, input bit abort);
      int rst_base, wr_base, beat_base, first_cyc, done_cyc;
      bit got;
      frame_id  = fid;
      ready_pct = rpct;
      for (int b = 0; b < 7; b++) begin
         for (int r = 0; r < 4; r++) begin
            q.push_back('{b, r, (r == 3), line_val(fid, blk_start[b] + r), (b == 6 && r == 3)});
         end
      end
      rst_base  = rst_pulses;
      wr_base   = wr_pulses;
      beat_base = beat_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("clear_state", {ram_rst, busy}, 2'b11);
      if (poke) begin
         @(posedge clk); #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         if (ram_full) got = 1'b1;
      end
      chk("fill_done", got, 1);
      chk("full_in_ready", {in_ready, ram_wr_en}, 0);
      chk("wr_pulses", wr_pulses - wr_base, 16);
      chk("ram_rst_pulses", rst_pulses - rst_base, 1);
      @(negedge clk);
      chk("scan_entry", {busy, out_valid, ram_rd_addr}, {1'b1, 1'b0, 9'd0});
      @(negedge clk);
      chk("first_valid", {out_valid, out_blk, out_row}, {1'b1, 9'd0, 9'd0});
      first_cyc = cyc;
      if (poke) begin
         repeat (6) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      if (abort) begin
         got = 1'b0;
         for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (beat_cnt - beat_base >= 5) got = 1'b1;
         end
         chk("abort_reach5", got, 1);
         @(posedge clk); #1 rst = 1'b1;
         q.delete();
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk("abort_idle", {busy, done, out_valid}, 0);
         repeat (5) @(negedge clk);
         return;
      end
      got = 1'b0;
      done_cyc = 0;
      for (int n = 0; n < 1000 && !got; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            done_cyc = cyc;
         end
      end
      chk("done_seen", got, 1);
      if (rpct == 100) chk("done_latency", done_cyc - first_cyc, 28);
      chk("beat_count", beat_cnt - beat_base, 28);
      chk("queue_empty", q.size(), 0);
      @(negedge clk);
      chk("done_hold", {busy, done, out_valid, ram_rd_addr}, {1'b0, 1'b0, 1'b0, 9'd15});
   endtask

   wire [33:0] outs = {ram_rst, busy, done, in_ready, ram_wr_en, out_valid, out_last,
                       ram_rd_addr, out_blk, out_row};

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", outs, 64'(34'h1 << 33));
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_outputs", outs, 0);
      end
      run_frame(1, 100, 1'b0, 1'b0);   // plain fill + scan
      run_frame(2, 100, 1'b1, 1'b0);   // start from DONE, pokes in FILL and SCAN
      run_frame(3, 30, 1'b0, 1'b0);    // backpressured scan
      run_frame(4, 100, 1'b0, 1'b1);   // aborted by reset mid-scan
      run_frame(5, 100, 1'b0, 1'b0);   // clean refill after abort
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
